vsync_line_counter: RTL and testbench

//   Vertical timing generator directly downstream of the horizontal sync stage.

---
 rtl/vsync_line_counter_pkg.sv | 25 ++
 rtl/pulse_one_shot.sv | 24 ++
 rtl/vsync_line_counter.sv | 150 +++++++++++++++
 tb/tb_vsync_line_counter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/vsync_line_counter_pkg.sv
// Shared vertical-timing definitions: default counter width, phase encoding
// and the phase-ordering helper. The hsync stage uses the same state codes.
package vsync_line_counter_pkg;

    localparam int DEF_WIDTH = 10;

    // Phase codes are fixed so that both timing stages decode them identically.
    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_BACK   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_FRONT  = 2'd3
    } vstate_t;

    // Phase that follows the given one within a frame.
    function automatic vstate_t next_phase(input vstate_t s);
        case (s)
            ST_SYNC:   return ST_BACK;
            ST_BACK:   return ST_ACTIVE;
            ST_ACTIVE: return ST_FRONT;
            default:   return ST_SYNC;
        endcase
    endfunction

endpackage

// File: rtl/pulse_one_shot.sv
// Rising-edge detector: pulse is high for the single cycle in which din is 1
// after having been 0 on the previous clock. A level held high for many cycles
// therefore produces exactly one pulse.
module pulse_one_shot (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    logic din_q;

    // Remember last cycle's input level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din;
        end
    end

    assign pulse = din & ~din_q;

endmodule

// File: rtl/vsync_line_counter.sv
// Vertical timing generator. Counts line events from the hsync stage and walks
// SYNC -> BACK -> ACTIVE -> FRONT once per frame, producing registered vsync,
// a one-clock FrameEnd strobe, the active line index and the vertical enable.
module vsync_line_counter
    import vsync_line_counter_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             LineEnd,
    input  logic [WIDTH-1:0] SynchPulse,
    input  logic [WIDTH-1:0] BackPorch,
    input  logic [WIDTH-1:0] ActiveVideo,
    input  logic [WIDTH-1:0] FrontPorch,
    output logic             vsync,
    output logic             FrameEnd,
    output logic [WIDTH-1:0] yposition,
    output logic             VideoOnY
);

    vstate_t          state;
    vstate_t          state_nxt;
    logic [WIDTH-1:0] ycount;
    logic [WIDTH-1:0] ycount_nxt;

    logic             line_evt;
    logic             frame_wrap;
    logic             is_last;

    // Shadow copies of the timing inputs, valid once primed is set.
    logic             primed;
    logic [WIDTH-1:0] sh_sync;
    logic [WIDTH-1:0] sh_back;
    logic [WIDTH-1:0] sh_active;
    logic [WIDTH-1:0] sh_front;

    logic [WIDTH-1:0] eff_sync;
    logic [WIDTH-1:0] eff_back;
    logic [WIDTH-1:0] eff_active;
    logic [WIDTH-1:0] eff_front;
    logic [WIDTH-1:0] phase_len;
    logic [WIDTH-1:0] last_idx;

    logic             vsync_d;
    logic             frame_end_d;
    logic [WIDTH-1:0] ypos_d;
    logic             video_d;

    // Line event strobe from the LineEnd level.
    pulse_one_shot u_line_evt (
        .clk   (clock),
        .rst_n (reset),
        .din   (LineEnd),
        .pulse (line_evt)
    );

    // The reset-time load of the shadow registers cannot use the inputs as
    // async reset values, so the first clock after release loads them and the
    // inputs are used directly until then.
    assign eff_sync   = primed ? sh_sync   : SynchPulse;
    assign eff_back   = primed ? sh_back   : BackPorch;
    assign eff_active = primed ? sh_active : ActiveVideo;
    assign eff_front  = primed ? sh_front  : FrontPorch;

    // Select the length of the phase currently being counted.
    always_comb begin
        phase_len = eff_sync;
        case (state)
            ST_SYNC:   phase_len = eff_sync;
            ST_BACK:   phase_len = eff_back;
            ST_ACTIVE: phase_len = eff_active;
            ST_FRONT:  phase_len = eff_front;
            default:   phase_len = eff_sync;
        endcase
    end

    // A zero-length phase behaves as one line long, so its last index is 0.
    assign last_idx   = (phase_len == '0) ? '0 : phase_len - WIDTH'(1);
    assign is_last    = (ycount == last_idx);
    assign frame_wrap = line_evt && (state == ST_FRONT) && is_last;

    // Shadow timing registers: refreshed at reset release and at frame wrap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            primed    <= 1'b0;
            sh_sync   <= '0;
            sh_back   <= '0;
            sh_active <= '0;
            sh_front  <= '0;
        end else if (!primed || frame_wrap) begin
            primed    <= 1'b1;
            sh_sync   <= SynchPulse;
            sh_back   <= BackPorch;
            sh_active <= ActiveVideo;
            sh_front  <= FrontPorch;
        end
    end

    // Phase state and line-in-phase counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= ST_SYNC;
            ycount <= '0;
        end else begin
            state  <= state_nxt;
            ycount <= ycount_nxt;
        end
    end

    // Next phase and line count, advanced only on a line event.
    always_comb begin
        state_nxt  = state;
        ycount_nxt = ycount;
        if (line_evt) begin
            if (is_last) begin
                state_nxt  = next_phase(state);
                ycount_nxt = '0;
            end else begin
                ycount_nxt = ycount + WIDTH'(1);
            end
        end
    end

    // Output decode from the next state so registered outputs track the
    // state register with no extra cycle of lag.
    always_comb begin
        vsync_d     = (state_nxt == ST_SYNC) ? VSYNC_POL : ~VSYNC_POL;
        video_d     = (state_nxt == ST_ACTIVE);
        ypos_d      = video_d ? ycount_nxt : '0;
        frame_end_d = frame_wrap;
    end

    // Registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vsync     <= ~VSYNC_POL;
            FrameEnd  <= 1'b0;
            yposition <= '0;
            VideoOnY  <= 1'b0;
        end else begin
            vsync     <= vsync_d;
            FrameEnd  <= frame_end_d;
            yposition <= ypos_d;
            VideoOnY  <= video_d;
        end
    end

endmodule

// File: tb/tb_vsync_line_counter.sv
// Self-checking bench for vsync_line_counter: table of frame-timing scenarios
// plus a hand-written mid-frame reset sequence. Expected outputs come from a
// frame-position model and travel through a scoreboard queue.
module tb_vsync_line_counter;

    localparam int W   = 10;
    localparam bit POL = 1'b0;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         LineEnd = 1'b0;
    logic [W-1:0] SynchPulse = '0;
    logic [W-1:0] BackPorch = '0;
    logic [W-1:0] ActiveVideo = '0;
    logic [W-1:0] FrontPorch = '0;
    logic         vsync;
    logic         FrameEnd;
    logic [W-1:0] yposition;
    logic         VideoOnY;

    vsync_line_counter #(.WIDTH(W), .VSYNC_POL(POL)) dut (
        .clock       (clock),
        .reset       (reset),
        .LineEnd     (LineEnd),
        .SynchPulse  (SynchPulse),
        .BackPorch   (BackPorch),
        .ActiveVideo (ActiveVideo),
        .FrontPorch  (FrontPorch),
        .vsync       (vsync),
        .FrameEnd    (FrameEnd),
        .yposition   (yposition),
        .VideoOnY    (VideoOnY)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic         vs;
        logic         fe;
        logic         von;
        logic [W-1:0] yp;
        string        tag;
    } exp_t;

    typedef struct {
        int    s, b, a, f;
        int    hold;
        int    lines;
        int    chg_at;
        int    chg_a;
        string name;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[5];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Model: lines completed in the current frame plus the frame's lengths.
    int m_n, m_s, m_b, m_a, m_f;

    function automatic int norm(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic exp_t model_out(input bit fe, input string tag);
        exp_t e;
        int   s, b, a;
        s = norm(m_s); b = norm(m_b); a = norm(m_a);
        e.tag = tag;
        e.fe  = fe;
        e.von = 1'b0;
        e.yp  = '0;
        e.vs  = (m_n < s) ? POL : ~POL;
        if (m_n >= s + b && m_n < s + b + a) begin
            e.von = 1'b1;
            e.yp  = W'(m_n - s - b);
        end
        return e;
    endfunction

    task automatic load_shadow();
        m_s = int'(SynchPulse); m_b = int'(BackPorch);
        m_a = int'(ActiveVideo); m_f = int'(FrontPorch);
    endtask

    task automatic check_next();
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard: got empty queue, want an entry");
        end else begin
            e = sb.pop_front();
            if ({vsync, FrameEnd, VideoOnY, yposition} !== {e.vs, e.fe, e.von, e.yp}) begin
                n_bad++;
                $display("FAIL %s: got vs=%b fe=%b von=%b yp=%0d, want vs=%b fe=%b von=%b yp=%0d",
                         e.tag, vsync, FrameEnd, VideoOnY, yposition, e.vs, e.fe, e.von, e.yp);
            end
        end
    endtask

    task automatic push_reset_vals(input string tag);
        exp_t e;
        e.vs = ~POL; e.fe = 1'b0; e.von = 1'b0; e.yp = '0; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic set_timing(input int s, input int b, input int a, input int f);
        SynchPulse = W'(s); BackPorch = W'(b); ActiveVideo = W'(a); FrontPorch = W'(f);
    endtask

    task automatic release_reset(input string name);
        @(negedge clock);
        reset = 1'b1;
        load_shadow();
        m_n = 0;
        sb.push_back(model_out(1'b0, {name, "/release"}));
        @(posedge clock); #1;
        check_next();
    endtask

    task automatic do_reset(input string name);
        @(negedge clock);
        reset   = 1'b0;
        LineEnd = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        push_reset_vals({name, "/in_reset"});
        check_next();
        release_reset(name);
    endtask

    // One line: LineEnd high for `hold` clocks within an 8-clock period.
    task automatic line(input int hold, input string name, input int idx);
        int   total;
        bit   fe;
        exp_t e;
        @(negedge clock);
        LineEnd = 1'b1;
        total = norm(m_s) + norm(m_b) + norm(m_a) + norm(m_f);
        m_n = (m_n + 1) % total;
        fe  = (m_n == 0);
        e   = model_out(fe, $sformatf("%s/line%0d", name, idx));
        sb.push_back(e);
        if (fe) load_shadow();
        @(posedge clock); #1;
        check_next();
        repeat (hold - 1) @(posedge clock);
        @(negedge clock);
        LineEnd = 1'b0;
        e.fe  = 1'b0;
        e.tag = $sformatf("%s/hold%0d", name, idx);
        sb.push_back(e);
        @(posedge clock); #1;
        check_next();
        repeat (8 - hold - 1) @(posedge clock);
    endtask

    initial begin
        vecs[0] = '{s:2, b:3, a:5, f:2, hold:1, lines:36, chg_at:-1, chg_a:0, name:"free_run"};
        vecs[1] = '{s:2, b:3, a:5, f:2, hold:1, lines:24, chg_at:6,  chg_a:3, name:"midframe_chg"};
        vecs[2] = '{s:2, b:0, a:5, f:2, hold:1, lines:20, chg_at:-1, chg_a:0, name:"zero_back"};
        vecs[3] = '{s:2, b:3, a:5, f:2, hold:3, lines:24, chg_at:-1, chg_a:0, name:"held_lineend"};
        vecs[4] = '{s:0, b:0, a:0, f:0, hold:1, lines:9,  chg_at:-1, chg_a:0, name:"all_zero"};

        for (int i = 0; i < 5; i++) begin
            set_timing(vecs[i].s, vecs[i].b, vecs[i].a, vecs[i].f);
            do_reset(vecs[i].name);
            for (int k = 1; k <= vecs[i].lines; k++) begin
                line(vecs[i].hold, vecs[i].name, k);
                if (k == vecs[i].chg_at) ActiveVideo = W'(vecs[i].chg_a);
            end
        end

        // Reset asserted mid-frame in ACTIVE (line 7, yposition 2).
        set_timing(2, 3, 5, 2);
        do_reset("midreset");
        for (int k = 1; k <= 7; k++) line(1, "midreset", k);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        push_reset_vals("midreset/async");
        check_next();
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            push_reset_vals($sformatf("midreset/held%0d", k));
            check_next();
        end
        release_reset("midreset");
        for (int k = 1; k <= 12; k++) line(1, "restart", k);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
